prbs_gen_chk: RTL

PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

---
 rtl/prbs_gen_chk.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk
//   PRBS generator and self-synchronising checker built on an N-bit XNOR
//   Fibonacci LFSR. Both sides process W bits per clock.
//
//   Generator: gen_en advances the state W steps. gen_data/gen_valid follow
//   one clock later. gen_load replaces the state with gen_seed, or with INIT
//   when gen_seed is all-ones. gen_load has priority over gen_en.
//
//   Checker: this is a SEARCH/LOCKED FSM that advances only when chk_en=1.
//   In SEARCH it seeds itself from the received data. In LOCKED it free-runs
//   and counts mismatched bits in a saturating counter.
//
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     gen_en, gen_load       generator advance / seed load
//     gen_seed [N-1:0]       seed value
//     gen_data [W-1:0]       generated word
//     gen_valid              gen_data updated this cycle
//     chk_en                 chk_data valid this cycle
//     chk_data [W-1:0]       received word
//     chk_clear              zero the error counter
//     chk_locked             checker is LOCKED
//     chk_err                last checked word had a mismatch while LOCKED
//     chk_err_cnt [CW-1:0]   saturating count of mismatched bits
//
//   Optional build macro PRBS_ERR_INJECT_EN:
//     adds input inject_err. Each 0->1 edge inverts gen_data[0] on the next
//     gen_en cycle. The generator state is not affected.

module prbs_gen_chk #(
    parameter int             N            = 7,
    parameter int             W            = 1,
    parameter logic [N-1:0]   INIT         = '0,
    parameter int             LOCK_WORDS   = 8,
    parameter int             UNLOCK_WORDS = 4,
    parameter int             CW           = 16
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef PRBS_ERR_INJECT_EN
    input  logic          inject_err,
`endif
    input  logic          gen_en,
    input  logic          gen_load,
    input  logic [N-1:0]  gen_seed,
    output logic [W-1:0]  gen_data,
    output logic          gen_valid,
    input  logic          chk_en,
    input  logic [W-1:0]  chk_data,
    input  logic          chk_clear,
    output logic          chk_locked,
    output logic          chk_err,
    output logic [CW-1:0] chk_err_cnt
);

    // Second feedback tap (1-based). The first tap is always bit N.
    localparam int TAP = (N == 7)  ? 6  :
                         (N == 9)  ? 5  :
                         (N == 11) ? 9  :
                         (N == 15) ? 14 :
                         (N == 23) ? 18 :
                         (N == 31) ? 28 : 1;

    localparam logic [N-1:0]  ONES    = '1;
    localparam int            PW      = $clog2(W + 1);
    localparam int            GW      = $clog2(LOCK_WORDS + 1);
    localparam int            BW      = $clog2(UNLOCK_WORDS + 1);
    localparam int            SW      = ((CW > PW) ? CW : PW) + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    generate
        if (!(N == 7 || N == 9 || N == 11 || N == 15 || N == 23 || N == 31)) begin : g_bad_n
            $error("prbs_gen_chk: unsupported LFSR width N");
        end
        if (W < 1 || W > N) begin : g_bad_w
            $error("prbs_gen_chk: W must satisfy 1 <= W <= N");
        end
        if (INIT == ONES) begin : g_bad_init
            $error("prbs_gen_chk: INIT must not be the all-ones lockup state");
        end
    endgenerate

    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
        return {s[N-2:0], ~(s[N-1] ^ s[TAP-1])};
    endfunction

    function automatic logic [N-1:0] lfsr_adv(input logic [N-1:0] s);
        logic [N-1:0] t;
        t = s;
        for (int i = 0; i < W; i++) begin
            t = lfsr_step(t);
        end
        return t;
    endfunction

    function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [PW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s > SW'(CNT_MAX)) ? CNT_MAX : s[CW-1:0];
    endfunction

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} chk_state_e;

    // ---------------- generator ----------------
    logic [N-1:0] gen_state_q, gen_state_d, gen_adv;
    logic [W-1:0] gen_data_q, gen_data_d;
    logic         gen_valid_q, gen_valid_d;
    logic [W-1:0] inj_mask;

`ifdef PRBS_ERR_INJECT_EN
    logic inj_prev_q, inj_pend_q, inj_pend_d, inj_arm, inj_fire;

    // An edge arms the injection. It fires on the first cycle in which the
    // generator actually advances.
    assign inj_arm    = inj_pend_q | (inject_err & ~inj_prev_q);
    assign inj_fire   = inj_arm & gen_en & ~gen_load;
    assign inj_pend_d = inj_arm & ~inj_fire;
    assign inj_mask   = W'(inj_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_prev_q <= 1'b0;
            inj_pend_q <= 1'b0;
        end else begin
            inj_prev_q <= inject_err;
            inj_pend_q <= inj_pend_d;
        end
    end
`else
    assign inj_mask = '0;
`endif

    always_comb begin
        gen_state_d = gen_state_q;
        gen_data_d  = gen_data_q;
        gen_valid_d = 1'b0;
        gen_adv     = lfsr_adv(gen_state_q);
        if (gen_load) begin
            gen_state_d = (gen_seed == ONES) ? INIT : gen_seed;
        end else if (gen_en) begin
            gen_state_d = gen_adv;
            gen_data_d  = gen_adv[W-1:0] ^ inj_mask;
            gen_valid_d = 1'b1;
        end
    end

    // ---------------- checker ----------------
    chk_state_e    st_q, st_d;
    logic [N-1:0]  local_q, local_d, chk_adv, seed;
    logic [W-1:0]  mism;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The self-seed value shifts the received word into the low bits of the
    // local state. This matches how the generator's own state evolves, so
    // the checker converges after ceil(N/W) words.
    generate
        if (W == N) begin : g_seed_full
            assign seed = chk_data;
        end else begin : g_seed_shift
            assign seed = {local_q[N-W-1:0], chk_data};
        end
    endgenerate

    always_comb begin
        st_d    = st_q;
        local_d = local_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        chk_adv = lfsr_adv(local_q);
        mism    = chk_adv[W-1:0] ^ chk_data;

        if (chk_clear) begin
            cnt_d = '0;
        end

        if (chk_en) begin
            case (st_q)
                SEARCH: begin
                    err_d = 1'b0;
                    if (|mism) begin
                        local_d = (seed == ONES) ? INIT : seed;
                        good_d  = '0;
                    end else begin
                        local_d = chk_adv;
                        good_d  = good_q + GW'(1);
                        if (good_q + GW'(1) == GW'(LOCK_WORDS)) begin
                            st_d   = LOCKED;
                            bad_d  = '0;
                            good_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    local_d = chk_adv;
                    err_d   = |mism;
                    // Builds on cnt_d, so a coincident clear restarts the
                    // count from this word's errors.
                    cnt_d   = sat_add(cnt_d, popcount(mism));
                    if (|mism) begin
                        if (bad_q + BW'(1) == BW'(UNLOCK_WORDS)) begin
                            st_d   = SEARCH;
                            good_d = '0;
                            bad_d  = '0;
                        end else begin
                            bad_d = bad_q + BW'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: st_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_state_q <= INIT;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            st_q        <= SEARCH;
            local_q     <= INIT;
            good_q      <= '0;
            bad_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            gen_state_q <= gen_state_d;
            gen_data_q  <= gen_data_d;
            gen_valid_q <= gen_valid_d;
            st_q        <= st_d;
            local_q     <= local_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gen_data    = gen_data_q;
    assign gen_valid   = gen_valid_q;
    assign chk_locked  = (st_q == LOCKED);
    assign chk_err     = err_q;
    assign chk_err_cnt = cnt_q;

endmodule
